uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  UART transmitter downstream of the button debounce/edge stage: each 1-cycle
//  'transmit' pulse sends the byte on 'data' as an 8N1 (optional parity) frame on 'txd'.
//  A one-deep pending slot absorbs a request arriving mid-frame; further ones flag overrun.
//  Sits between the debounced push-button stage and the board TxD pin.
// PARAMETERS
//  CLK_FREQ    100_000_000  input clock frequency, Hz
//  BAUD        9600         line rate, bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (floor, >=2)
//  PARITY_EN   0            1 = insert parity bit after data bits
//  PARITY_ODD  0            1 = odd parity, 0 = even (ignored if PARITY_EN=0)
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  reset_n   in   1  synchronous, active-low reset
//  transmit  in   1  1-cycle send request (from debounce stage)
//  data      in   8  byte to send, sampled on the cycle transmit=1
//  txd       out  1  serial line, idle high, registered
//  busy      out  1  high while a frame is on the line
//  done      out  1  1-cycle pulse in the last cycle of each stop bit
//  overrun   out  1  1-cycle pulse when a request is dropped
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): txd=1, busy=0, done=0, overrun=0, FSM=IDLE,
//    pending slot empty, baud counter=0. Mid-frame reset aborts; txd=1 next edge.
//  - FSM: IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> IDLE|START.
//  - Each of START/DATA/PARITY/STOP bit lasts exactly CLKS_PER_BIT cycles; baud
//    counter reloads to 0 on every state entry, tick when count==CLKS_PER_BIT-1.
//  - Latency: transmit=1 at edge N in IDLE -> txd=0, busy=1 from edge N+1.
//  - Shift register loaded with data at the accepting edge; later data changes ignored.
//  - Parity bit = ^data XOR PARITY_ODD, computed from the latched byte.
//  - done=1 in final cycle of STOP; busy stays 1 through that cycle.
//  - After STOP: pending valid -> START immediately (no idle cycle), slot cleared;
//    else IDLE, busy=0 next edge.
//  - transmit while busy: pending empty -> capture data into pending; pending full ->
//    request dropped, overrun=1 next cycle, pending keeps its older byte.
//  - transmit in final STOP cycle with pending full: pending moves to shifter and the
//    new byte enters pending same edge (no overrun). With pending empty: new byte starts
//    directly (same as pending path).
//  - Bit counter 3 bits, counts 0..7, no wrap beyond; baud counter width
//    $clog2(CLKS_PER_BIT).
// STRUCTURE
//  - uart_pkg: state encoding (IDLE/START/DATA/PARITY/STOP), function
//    clks_per_bit(CLK_FREQ,BAUD), DATA_BITS=8 constant.
//  - Sub-module uart_baud_tick: counter with sync clear, emits tick at CLKS_PER_BIT-1.
//  - Top holds FSM, shifter, bit counter, pending slot, output registers.
// TESTING (CLK_FREQ=100, BAUD=10 -> 10 clk/bit)
//  1 reset_n=0 for 3 cycles -> txd=1, busy=0, done=0, overrun=0.
//  2 transmit+data=8'hA5, PARITY_EN=0 -> txd: 0,1,0,1,0,0,1,0,1,1 each 10 clk;
//    busy 100 cycles, done at cycle 100.
//  3 PARITY_EN=1, ODD=0, data=8'h07 -> parity bit=1, frame 110 cycles.
//  4 data=8'h41 then transmit at cycle 30 with data=8'h42 -> 8'h42 frame starts
//    cycle after 8'h41 stop, no idle gap; third request at cycle 40 -> overrun pulse.
//  5 reset_n=0 at cycle 45 of a frame -> txd=1, busy=0 next edge; new request sends clean.
//  6 transmit in final STOP cycle, pending full -> both queued bytes sent, overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, frame size and
// the clock-to-baud divider calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Floor division, clamped so every bit lasts at least two clocks.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    int r;
    r = clk_freq / baud;
    if (r < 2) r = 2;
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit,
// and can be held at zero by a synchronous clear.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 2,
  parameter int CW           = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          tick
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign count = count_q;
  assign tick  = (count_q == LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || tick) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one frame per transmit pulse, with a single-entry pending slot
// so a request made during a frame follows it back-to-back.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       transmit,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_NEAR_END = CW'(CPB - 2);
  localparam logic PAR_ODD  = (PARITY_ODD != 0);
  localparam logic PAR_USED = (PARITY_EN != 0);

  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [2:0]           bit_q, bit_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [DATA_BITS-1:0] pend_data_q, pend_data_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  logic [CW-1:0]        baud_cnt;
  logic                 baud_tick;
  logic                 baud_clear;
  logic                 load_en;
  logic [DATA_BITS-1:0] load_byte;
  logic                 last_stop;

  // Every non-idle state is left only on a tick, where the counter wraps to zero by
  // itself, so holding it clear in IDLE gives a fresh count on every state entry.
  assign baud_clear = (state_q == ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CPB),
    .CW          (CW)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (baud_clear),
    .count  (baud_cnt),
    .tick   (baud_tick)
  );

  assign last_stop = (state_q == ST_STOP) && baud_tick;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    par_d        = par_q;
    bit_d        = bit_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    txd_d        = txd_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = 1'b0;
    load_en      = 1'b0;
    load_byte    = data;

    case (state_q)
      ST_IDLE: begin
        if (transmit) load_en = 1'b1;
      end
      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_q == 3'd7) begin
            if (PAR_USED) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        // done is registered, so raise it one cycle ahead of the final stop cycle.
        if (baud_cnt == CNT_NEAR_END) done_d = 1'b1;
        if (baud_tick) begin
          if (pend_valid_q) begin
            load_en      = 1'b1;
            load_byte    = pend_data_q;
            pend_valid_d = transmit;
            if (transmit) pend_data_d = data;
          end else if (transmit) begin
            load_en = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (transmit && (state_q != ST_IDLE) && !last_stop) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_data_d  = data;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (load_en) begin
      state_d = ST_START;
      shift_d = load_byte;
      par_d   = (^load_byte) ^ PAR_ODD;
      bit_d   = 3'd0;
      txd_d   = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      par_q        <= 1'b0;
      bit_q        <= 3'd0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      bit_q        <= bit_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign txd     = txd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame at 10 clocks per bit: a plain-parity and an even-parity
// instance share stimulus and are each checked every cycle against a frame-level model.
module tb_uart_tx_frame;

  localparam int CPB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       transmit;
  logic [7:0] data;
  logic       txd_a, busy_a, done_a, ovr_a;
  logic       txd_b, busy_b, done_b, ovr_b;

  uart_tx_frame #(.CLK_FREQ(100), .BAUD(10), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .transmit(transmit), .data(data),
    .txd(txd_a), .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  uart_tx_frame #(.CLK_FREQ(100), .BAUD(10), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .transmit(transmit), .data(data),
    .txd(txd_b), .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Frame-level model: each frame is a list of line bits, pos counts cycles into it.
  int         m_pos [2];
  int         m_len [2];
  logic       m_bits[2][11];
  logic       m_pv  [2];
  logic [7:0] m_pd  [2];
  logic [3:0] m_exp [2];
  bit         m_live = 1'b0;

  task automatic m_start(input int i, input logic [7:0] b);
    m_pos[i] = 0;
    m_bits[i][0] = 1'b0;
    for (int k = 0; k < 8; k++) m_bits[i][k+1] = b[k];
    if (i == 1) begin
      m_bits[i][9]  = ^b;
      m_bits[i][10] = 1'b1;
      m_len[i] = 11 * CPB;
    end else begin
      m_bits[i][9]  = 1'b1;
      m_bits[i][10] = 1'b1;
      m_len[i] = 10 * CPB;
    end
  endtask

  task automatic m_step();
    for (int i = 0; i < 2; i++) begin
      logic ovr;
      ovr = 1'b0;
      if (!reset_n) begin
        m_pos[i] = -1;
        m_pv[i]  = 1'b0;
        m_live   = 1'b1;
      end else if (m_pos[i] < 0) begin
        if (transmit) m_start(i, data);
      end else if (m_pos[i] == m_len[i] - 1) begin
        if (m_pv[i]) begin
          m_start(i, m_pd[i]);
          m_pv[i] = transmit;
          if (transmit) m_pd[i] = data;
        end else if (transmit) begin
          m_start(i, data);
        end else begin
          m_pos[i] = -1;
        end
      end else begin
        m_pos[i]++;
        if (transmit) begin
          if (!m_pv[i]) begin
            m_pv[i] = 1'b1;
            m_pd[i] = data;
          end else begin
            ovr = 1'b1;
          end
        end
      end
      if (m_pos[i] < 0) m_exp[i] = {1'b1, 1'b0, 1'b0, ovr};
      else m_exp[i] = {m_bits[i][m_pos[i] / CPB], 1'b1, (m_pos[i] == m_len[i] - 1), ovr};
    end
  endtask

  initial forever begin
    @(posedge clk);
    m_step();
  end

  task automatic chk(input string nm, input int i, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d got %b want %b at %0t", nm, i, got, want, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("txd",     0, txd_a,  m_exp[0][3]);
      chk("busy",    0, busy_a, m_exp[0][2]);
      chk("done",    0, done_a, m_exp[0][1]);
      chk("overrun", 0, ovr_a,  m_exp[0][0]);
      chk("txd",     1, txd_b,  m_exp[1][3]);
      chk("busy",    1, busy_b, m_exp[1][2]);
      chk("done",    1, done_b, m_exp[1][1]);
      chk("overrun", 1, ovr_b,  m_exp[1][0]);
    end
  end

  task automatic lit(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got 0x%0h want 0x%0h at %0t", nm, got, want, $time);
    end else begin
      $display("check %s = 0x%0h ok", nm, got);
    end
  endtask

  // Capture counters, sampled mid-bit and per cycle from the first frame cycle.
  logic [31:0] mid_a, mid_b;
  int busy_cnt_a, busy_cnt_b, done_at_a, done_at_b, ovr_cnt_a, ovr_at_a;

  task automatic cap_clear();
    mid_a = '0; mid_b = '0;
    busy_cnt_a = 0; busy_cnt_b = 0; done_at_a = 0; done_at_b = 0;
    ovr_cnt_a = 0; ovr_at_a = 0;
  endtask

  task automatic rec(input int c);
    if (c % 10 == 5) begin
      mid_a[c/10] = txd_a;
      mid_b[c/10] = txd_b;
    end
    busy_cnt_a += int'(busy_a);
    busy_cnt_b += int'(busy_b);
    if (done_a && done_at_a == 0) done_at_a = c;
    if (done_b && done_at_b == 0) done_at_b = c;
    ovr_cnt_a += int'(ovr_a);
    if (ovr_a && ovr_at_a == 0) ovr_at_a = c;
  endtask

  task automatic pulse(input logic [7:0] b);
    transmit = 1'b1;
    data     = b;
    @(negedge clk);
    transmit = 1'b0;
    data     = 8'($urandom);
  endtask

  task automatic capture(input int ncyc);
    cap_clear();
    for (int c = 1; c <= ncyc; c++) begin
      rec(c);
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    transmit = 1'b0;
    data     = 8'h00;
    repeat (3) @(negedge clk);
    lit("reset txd_a",  int'(txd_a),  1);
    lit("reset busy_a", int'(busy_a), 0);
    lit("reset done_a", int'(done_a), 0);
    lit("reset ovr_a",  int'(ovr_a),  0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("txn A5 single frame");
    pulse(8'hA5);
    capture(130);
    lit("A5 line bits", int'(mid_a[9:0]), 10'b1101001010);
    lit("A5 busy cycles", busy_cnt_a, 100);
    lit("A5 done cycle", done_at_a, 100);
    lit("A5 parity frame busy", busy_cnt_b, 110);

    $display("txn 07 parity frame");
    pulse(8'h07);
    capture(130);
    lit("07 parity bit", int'(mid_b[9]), 1);
    lit("07 parity frame busy", busy_cnt_b, 110);
    lit("07 parity done cycle", done_at_b, 110);
    lit("07 plain line bits", int'(mid_a[9:0]), 10'b1000001110);

    $display("txn 41/42 pending + 43 overrun");
    pulse(8'h41);
    cap_clear();
    for (int c = 1; c <= 230; c++) begin
      rec(c);
      transmit = (c == 29 || c == 39);
      data = (c == 29) ? 8'h42 : (c == 39) ? 8'h43 : 8'($urandom);
      @(negedge clk);
    end
    transmit = 1'b0;
    lit("41 line bits", int'(mid_a[9:0]), 10'b1010000010);
    lit("42 line bits", int'(mid_a[19:10]), 10'b1010000100);
    lit("41+42 busy no gap", busy_cnt_a, 200);
    lit("overrun pulses", ovr_cnt_a, 1);
    lit("overrun cycle", ovr_at_a, 40);

    $display("txn 5A aborted by reset at cycle 45");
    pulse(8'h5A);
    repeat (44) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    lit("abort txd_a",  int'(txd_a),  1);
    lit("abort busy_a", int'(busy_a), 0);
    lit("abort busy_b", int'(busy_b), 0);
    reset_n = 1'b1;
    @(negedge clk);
    pulse(8'hC3);
    capture(130);
    lit("C3 after abort bits", int'(mid_a[9:0]), 10'b1110000110);
    lit("C3 busy cycles", busy_cnt_a, 100);

    $display("txn 11/22 + 33 in final stop cycle");
    pulse(8'h11);
    repeat (20) @(negedge clk);
    pulse(8'h22);
    n = 0;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    lit("done seen before bound", int'(n < 200), 1);
    pulse(8'h33);
    capture(230);
    lit("22 line bits", int'(mid_a[9:0]), 10'b1001000100);
    lit("33 line bits", int'(mid_a[19:10]), 10'b1001100110);
    lit("22+33 busy no gap", busy_cnt_a, 200);
    lit("no overrun final stop", ovr_cnt_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
